// File: rtl/uv_sram_dp_if.sv
// Bus bundle for the dual-port SRAM model: one write port, one read port,
// plus read-valid and collision strobes returned to the requester.
interface uv_sram_dp_if #(
  parameter int AW = 8,
  parameter int DW = 32,
  parameter int MW = DW / 8
);
  logic          wr_ce;
  logic [AW-1:0] wr_a;
  logic [DW-1:0] wr_d;
  logic [MW-1:0] wr_m;
  logic          rd_ce;
  logic [AW-1:0] rd_a;
  logic [DW-1:0] rd_q;
  logic          rd_vld;
  logic          col;

  modport master (
    output wr_ce, wr_a, wr_d, wr_m, rd_ce, rd_a,
    input  rd_q, rd_vld, col
  );

  modport slave (
    input  wr_ce, wr_a, wr_d, wr_m, rd_ce, rd_a,
    output rd_q, rd_vld, col
  );
endinterface

// File: rtl/uv_sram_dp.sv
// Behavioural dual-port SRAM: byte-masked write port, pipelined read port with
// configurable latency, selectable read-during-write result and collision strobe.
module uv_sram_dp #(
  parameter int RAM_AW   = 8,
  parameter int RAM_DP   = 2 ** RAM_AW,
  parameter int RAM_DW   = 32,
  parameter int RAM_MW   = RAM_DW / 8,
  parameter int RAM_ME   = 1,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input logic         clk,
  input logic         rst,
  uv_sram_dp_if.slave bus
);
  localparam int              NB   = RAM_DW / 8;
  localparam logic [RAM_AW:0] DP_L = (RAM_AW + 1)'(RAM_DP);

  if (RD_LAT < 1 || RD_LAT > 4 || (RAM_DW % 8) != 0) begin : g_param_err
    $error("uv_sram_dp: RD_LAT must be 1..4 and RAM_DW a multiple of 8");
  end

  logic [RAM_DW-1:0] mem_q [RAM_DP];
  logic              vld_q [RD_LAT];
  logic              vld_d [RD_LAT];
  logic [RAM_DW-1:0] dat_q [RD_LAT];
  logic [RAM_DW-1:0] dat_d [RD_LAT];
  logic              col_q;
  logic              col_d;
  logic              wr_in_s;
  logic              rd_in_s;
  logic [RAM_DW-1:0] wr_old_s;
  logic [RAM_DW-1:0] wr_new_s;
  logic [RAM_DW-1:0] rd_data_s;

  // Bytes beyond the mask width, or every byte when masking is off, take new data.
  function automatic logic [RAM_DW-1:0] merge_bytes(
    input logic [RAM_DW-1:0] old_w,
    input logic [RAM_DW-1:0] new_w,
    input logic [RAM_MW-1:0] m
  );
    logic [RAM_DW-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++) begin
      if (RAM_ME == 32'sd0 || i >= RAM_MW) begin
        r[8*i +: 8] = new_w[8*i +: 8];
      end else if (m[i]) begin
        r[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        r[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return r;
  endfunction

  always_comb begin
    wr_in_s  = ({1'b0, bus.wr_a} < DP_L);
    rd_in_s  = ({1'b0, bus.rd_a} < DP_L);
    wr_old_s = wr_in_s ? mem_q[bus.wr_a] : {RAM_DW{1'b0}};
    wr_new_s = merge_bytes(wr_old_s, bus.wr_d, bus.wr_m);
    col_d    = bus.wr_ce && bus.rd_ce && wr_in_s && rd_in_s && (bus.wr_a == bus.rd_a);
    if (!rd_in_s) begin
      rd_data_s = {RAM_DW{1'b0}};
    end else if (col_d && RDW_MODE != 32'sd0) begin
      rd_data_s = wr_new_s;
    end else begin
      rd_data_s = mem_q[bus.rd_a];
    end
  end

  // Each stage only reloads when a valid result enters it, so the last stage holds rd_q.
  for (genvar k = 0; k < RD_LAT; k++) begin : g_stage
    logic              v_in_s;
    logic [RAM_DW-1:0] d_in_s;
    if (k == 0) begin : g_head
      assign v_in_s = bus.rd_ce;
      assign d_in_s = rd_data_s;
    end else begin : g_tail
      assign v_in_s = vld_q[k-1];
      assign d_in_s = dat_q[k-1];
    end
    assign vld_d[k] = v_in_s;
    assign dat_d[k] = v_in_s ? d_in_s : dat_q[k];
  end

  always_ff @(posedge clk) begin
    if (!rst && bus.wr_ce && wr_in_s) begin
      mem_q[bus.wr_a] <= wr_new_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < RD_LAT; k++) begin
        vld_q[k] <= 1'b0;
        dat_q[k] <= {RAM_DW{1'b0}};
      end
      col_q <= 1'b0;
    end else begin
      for (int k = 0; k < RD_LAT; k++) begin
        vld_q[k] <= vld_d[k];
        dat_q[k] <= dat_d[k];
      end
      col_q <= col_d;
    end
  end

  assign bus.rd_q   = dat_q[RD_LAT-1];
  assign bus.rd_vld = vld_q[RD_LAT-1];
  assign bus.col    = col_q;
endmodule

// File: tb/tb_uv_sram_dp.sv
// Self-checking bench: three differently configured SRAMs share one stimulus
// stream and are compared every cycle against a word-level reference model.
module tb_uv_sram_dp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wce, rce;
  logic [7:0]  wa, ra;
  logic [31:0] wd;
  logic [3:0]  wm;

  always #5 clk = ~clk;

  localparam int C_DP  [3] = '{256, 200, 200};
  localparam int C_ME  [3] = '{1, 0, 1};
  localparam int C_LAT [3] = '{1, 3, 4};
  localparam int C_RDW [3] = '{0, 1, 1};

  uv_sram_dp_if #(.AW(8), .DW(32), .MW(4)) b0 ();
  uv_sram_dp_if #(.AW(8), .DW(32), .MW(4)) b1 ();
  uv_sram_dp_if #(.AW(8), .DW(32), .MW(4)) b2 ();

  assign b0.wr_ce = wce; assign b0.wr_a = wa; assign b0.wr_d = wd;
  assign b0.wr_m  = wm;  assign b0.rd_ce = rce; assign b0.rd_a = ra;
  assign b1.wr_ce = wce; assign b1.wr_a = wa; assign b1.wr_d = wd;
  assign b1.wr_m  = wm;  assign b1.rd_ce = rce; assign b1.rd_a = ra;
  assign b2.wr_ce = wce; assign b2.wr_a = wa; assign b2.wr_d = wd;
  assign b2.wr_m  = wm;  assign b2.rd_ce = rce; assign b2.rd_a = ra;

  uv_sram_dp #(.RAM_AW(8), .RAM_DP(256), .RAM_DW(32), .RAM_MW(4), .RAM_ME(1),
               .RD_LAT(1), .RDW_MODE(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  uv_sram_dp #(.RAM_AW(8), .RAM_DP(200), .RAM_DW(32), .RAM_MW(4), .RAM_ME(0),
               .RD_LAT(3), .RDW_MODE(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  uv_sram_dp #(.RAM_AW(8), .RAM_DP(200), .RAM_DW(32), .RAM_MW(4), .RAM_ME(1),
               .RD_LAT(4), .RDW_MODE(1)) u2 (.clk(clk), .rst(rst), .bus(b2));

  logic [31:0] obs_q [3];
  logic        obs_v [3];
  logic        obs_c [3];
  assign obs_q[0] = b0.rd_q; assign obs_v[0] = b0.rd_vld; assign obs_c[0] = b0.col;
  assign obs_q[1] = b1.rd_q; assign obs_v[1] = b1.rd_vld; assign obs_c[1] = b1.col;
  assign obs_q[2] = b2.rd_q; assign obs_v[2] = b2.rd_vld; assign obs_c[2] = b2.col;

  typedef struct {
    int          due;
    logic [31:0] d;
  } rd_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] mem  [3][256];
  logic [31:0] hold [3];
  logic        col_e [3];
  rd_t         rq [3][$];

  function automatic logic [31:0] mrg(int j, logic [31:0] o, logic [31:0] n, logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) begin
      if (C_ME[j] == 0 || m[b]) r[8*b +: 8] = n[8*b +: 8];
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 3; j++) begin
      rq[j].delete();
      hold[j]  = 32'h0;
      col_e[j] = 1'b0;
    end
  endtask

  // One clock edge of the reference: read sees pre-write contents unless forwarding applies.
  task automatic model_step();
    rd_t         e;
    logic        in_r, in_w, c;
    logic [31:0] nw;
    for (int j = 0; j < 3; j++) begin
      in_r = (int'(ra) < C_DP[j]);
      in_w = (int'(wa) < C_DP[j]);
      nw   = mrg(j, mem[j][wa], wd, wm);
      c    = wce && rce && in_r && in_w && (wa == ra);
      if (rce) begin
        e.due = cyc + C_LAT[j] - 1;
        if (!in_r)                  e.d = 32'h0;
        else if (c && C_RDW[j] == 1) e.d = nw;
        else                         e.d = mem[j][ra];
        rq[j].push_back(e);
      end
      if (wce && in_w) mem[j][wa] = nw;
      col_e[j] = c;
    end
  endtask

  task automatic check_all(string ph);
    logic ev;
    for (int j = 0; j < 3; j++) begin
      ev = 1'b0;
      if (rq[j].size() > 0 && rq[j][0].due == cyc) begin
        ev      = 1'b1;
        hold[j] = rq[j][0].d;
        void'(rq[j].pop_front());
      end
      chk($sformatf("%s_u%0d_vld", ph, j), {31'h0, obs_v[j]}, {31'h0, ev});
      chk($sformatf("%s_u%0d_q", ph, j), obs_q[j], hold[j]);
      chk($sformatf("%s_u%0d_col", ph, j), {31'h0, obs_c[j]}, {31'h0, col_e[j]});
    end
  endtask

  task automatic edge_chk(string ph);
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else     model_step();
    #1;
    check_all(ph);
  endtask

  task automatic drive(logic w, logic [7:0] a, logic [31:0] d, logic [3:0] m,
                       logic r, logic [7:0] b);
    wce = w; wa = a; wd = d; wm = m; rce = r; ra = b;
  endtask

  task automatic idle(string ph, int n);
    drive(1'b0, 8'h0, 32'h0, 4'h0, 1'b0, 8'h0);
    for (int i = 0; i < n; i++) edge_chk(ph);
  endtask

  initial begin
    drive(1'b0, 8'h0, 32'h0, 4'h0, 1'b0, 8'h0);
    model_reset();
    #1;
    check_all("rst0");
    for (int i = 0; i < 3; i++) edge_chk("rst");
    rst = 1'b0;

    for (int a = 0; a < 256; a++) begin
      drive(1'b1, 8'(a), $urandom, 4'hF, 1'b0, 8'h0);
      edge_chk("preload");
    end

    drive(1'b1, 8'h05, 32'hDEADBEEF, 4'hF, 1'b0, 8'h00); edge_chk("lat_wr");
    drive(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h05);        edge_chk("lat_rd");
    idle("lat", 5);

    drive(1'b1, 8'h10, 32'h11223344, 4'hF, 1'b0, 8'h00); edge_chk("mask_w1");
    drive(1'b1, 8'h10, 32'hAABBCCDD, 4'h5, 1'b0, 8'h00); edge_chk("mask_w2");
    drive(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h10);        edge_chk("mask_rd");
    idle("mask", 5);

    drive(1'b1, 8'h20, 32'h0, 4'hF, 1'b0, 8'h00);        edge_chk("col_pre");
    drive(1'b1, 8'h20, 32'hCAFEF00D, 4'h3, 1'b1, 8'h20); edge_chk("col_hit");
    idle("col", 5);

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(i), 32'h100 + 32'(i), 4'hF, 1'b0, 8'h00);
      edge_chk("pipe_wr");
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'(i));
      edge_chk("pipe_rd");
    end
    idle("pipe", 6);

    drive(1'b1, 8'd220, 32'h12345678, 4'hF, 1'b0, 8'd0); edge_chk("oor_wr");
    drive(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd220);        edge_chk("oor_rd");
    drive(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd20);         edge_chk("oor_rd20");
    idle("oor", 6);

    // Reset lands between edges while the longest pipeline still holds both reads.
    drive(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h05); edge_chk("arst_rd0");
    drive(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h10); edge_chk("arst_rd1");
    idle("arst_gap", 1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("arst_now");
    edge_chk("arst_hold");
    edge_chk("arst_hold");
    rst = 1'b0;
    idle("arst_post", 6);
    drive(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h10); edge_chk("arst_rdback");
    idle("arst_rdback", 5);

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255)),
            $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255)));
      edge_chk("rand");
    end
    idle("drain", 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
